udp_rx_port_fifo: RTL and testbench

- Sits directly downstream of the stack's UDPv4 receive interface, between the UDP layer and one application socket.
- Filters incoming datagrams by destination port and buffers accepted payloads in a speculative data FIFO.
- Commits a datagram only on the UDP layer's commit strobe and rolls it back on drop.
- Presents complete datagrams, with source IP, source port and length metadata, to the application on a simple pull interface.

---
 rtl/udp_rx_port_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_udp_rx_port_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_port_fifo.sv
// udp_rx_port_fifo: destination-port filter and speculative datagram FIFO
// between the UDP receive layer and a single application socket.
// Payload words are written speculatively and only become readable once the
// UDP layer commits the datagram; a drop (or a new start with no terminator)
// rewinds the speculative write pointer. Committed datagrams are described
// by a metadata FIFO entry {src_ip, src_port, len, end_ptr}.
// Optional: define UDP_RX_FIFO_PERF_EN to add saturating perf counters.
module udp_rx_port_fifo #(
    parameter logic [15:0] LISTEN_PORT = 16'd5000,
    parameter int          DATA_DEPTH  = 512,
    parameter int          FRAME_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_start,
    input  logic [31:0] rx_src_ip,
    input  logic [15:0] rx_src_port,
    input  logic [15:0] rx_dst_port,
    input  logic [15:0] rx_payload_len,
    input  logic        rx_data_valid,
    input  logic [2:0]  rx_bytes_valid,
    input  logic [31:0] rx_data,
    input  logic        rx_commit,
    input  logic        rx_drop,
    output logic        out_frame_valid,
    output logic [31:0] out_src_ip,
    output logic [15:0] out_src_port,
    output logic [15:0] out_len,
    input  logic        out_rd_en,
    output logic        out_data_valid,
    output logic [31:0] out_data,
    input  logic        out_pop
`ifdef UDP_RX_FIFO_PERF_EN
    ,
    output logic [31:0] perf_frames_accepted,
    output logic [31:0] perf_frames_dropped_full,
    output logic [31:0] perf_frames_dropped_bad
`endif
);

    localparam int AW  = $clog2(DATA_DEPTH);
    localparam int FAW = $clog2(FRAME_DEPTH);
    localparam logic [AW:0] PONE = 1;
    localparam logic [FAW:0] FONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DISCARD} state_t;

    state_t r_state, w_state_nxt;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]  r_wr_spec, r_wr_commit, r_rd_ptr;
    logic [FAW:0] r_mwr, r_mrd;

    logic [31:0] r_mem  [DATA_DEPTH];
    logic [31:0] r_m_ip [FRAME_DEPTH];
    logic [15:0] r_m_port [FRAME_DEPTH];
    logic [15:0] r_m_len [FRAME_DEPTH];
    logic [AW:0] r_m_end [FRAME_DEPTH];

    logic [31:0] r_hdr_ip;
    logic [15:0] r_hdr_port, r_hdr_len;
    logic [16:0] r_need, r_wcnt;

    logic        r_out_fv, r_out_dv;
    logic [31:0] r_out_ip, r_out_data;
    logic [15:0] r_out_port, r_out_len;

    logic        w_latch, w_rollback, w_wr_en, w_commit, w_rej_full, w_bad;
    logic [AW:0] w_used, w_spec_nxt, w_head_end;
    logic [16:0] w_free, w_need;
    logic        w_port_ok, w_room_ok, w_meta_full, w_meta_ne, w_rd, w_pop;
    logic        w_unused;

    // Byte-enables are not needed: the length field already defines the payload.
    assign w_unused = ^rx_bytes_valid;

    // Admission is checked against committed data only; in IDLE the
    // speculative and committed pointers are equal, and on a mid-frame start
    // the partial frame is being rolled back in the same cycle.
    assign w_used      = r_wr_commit - r_rd_ptr;
    assign w_free      = 17'(DATA_DEPTH) - 17'(w_used);
    assign w_need      = ({1'b0, rx_payload_len} + 17'd3) >> 2;
    assign w_meta_full = (r_mwr[FAW] != r_mrd[FAW]) &&
                         (r_mwr[FAW-1:0] == r_mrd[FAW-1:0]);
    assign w_port_ok   = (rx_dst_port == LISTEN_PORT);
    assign w_room_ok   = (w_free >= w_need) && !w_meta_full;
    assign w_spec_nxt  = w_wr_en ? r_wr_spec + PONE : r_wr_spec;

    assign w_meta_ne   = (r_mwr != r_mrd);
    assign w_head_end  = r_m_end[r_mrd[FAW-1:0]];
    assign w_pop       = out_pop && w_meta_ne;
    assign w_rd        = out_rd_en && w_meta_ne && !out_pop && (r_rd_ptr != w_head_end);

    // Write FSM next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_rollback  = 1'b0;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_rej_full  = 1'b0;
        w_bad       = 1'b0;
        if (rx_start) begin
            // A start always abandons any unterminated frame first.
            w_rollback = 1'b1;
            if (w_port_ok && w_room_ok) begin
                w_latch     = 1'b1;
                w_state_nxt = S_ACCEPT;
            end else begin
                w_rej_full  = w_port_ok;
                w_state_nxt = S_DISCARD;
            end
        end else begin
            case (r_state)
                S_ACCEPT: begin
                    w_wr_en = rx_data_valid && (r_wcnt < r_need);
                    if (rx_commit) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (rx_drop) begin
                        w_rollback  = 1'b1;
                        w_bad       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (rx_commit || rx_drop) w_state_nxt = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Write-side state: FSM, speculative/committed pointers, header latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
            r_mwr       <= '0;
            r_need      <= '0;
            r_wcnt      <= '0;
            r_hdr_ip    <= '0;
            r_hdr_port  <= '0;
            r_hdr_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rollback) r_wr_spec <= r_wr_commit;
            else            r_wr_spec <= w_spec_nxt;
            if (w_wr_en) r_wcnt <= r_wcnt + 17'd1;
            if (w_latch) begin
                r_need     <= w_need;
                r_wcnt     <= '0;
                r_hdr_ip   <= rx_src_ip;
                r_hdr_port <= rx_src_port;
                r_hdr_len  <= rx_payload_len;
            end
            // The word written alongside a commit is part of the snapshot.
            if (w_commit) begin
                r_wr_commit <= w_spec_nxt;
                r_mwr       <= r_mwr + FONE;
            end
        end
    end

    // Payload RAM and metadata storage (no reset needed; guarded by pointers).
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_spec[AW-1:0]] <= rx_data;
        if (w_commit) begin
            r_m_ip[r_mwr[FAW-1:0]]   <= r_hdr_ip;
            r_m_port[r_mwr[FAW-1:0]] <= r_hdr_port;
            r_m_len[r_mwr[FAW-1:0]]  <= r_hdr_len;
            r_m_end[r_mwr[FAW-1:0]]  <= w_spec_nxt;
        end
    end

    // Read side: word reads within the head frame, pop skips its remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_mrd      <= '0;
            r_out_fv   <= 1'b0;
            r_out_dv   <= 1'b0;
            r_out_data <= '0;
            r_out_ip   <= '0;
            r_out_port <= '0;
            r_out_len  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= w_head_end;
                r_mrd    <= r_mrd + FONE;
            end else if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PONE;
            end
            r_out_dv <= w_rd;
            if (w_rd) r_out_data <= r_mem[r_rd_ptr[AW-1:0]];
            r_out_fv   <= w_meta_ne;
            r_out_ip   <= w_meta_ne ? r_m_ip[r_mrd[FAW-1:0]]   : 32'd0;
            r_out_port <= w_meta_ne ? r_m_port[r_mrd[FAW-1:0]] : 16'd0;
            r_out_len  <= w_meta_ne ? r_m_len[r_mrd[FAW-1:0]]  : 16'd0;
        end
    end

    assign out_frame_valid = r_out_fv;
    assign out_src_ip      = r_out_ip;
    assign out_src_port    = r_out_port;
    assign out_len         = r_out_len;
    assign out_data_valid  = r_out_dv;
    assign out_data        = r_out_data;

`ifdef UDP_RX_FIFO_PERF_EN
    logic [31:0] r_perf_acc, r_perf_full, r_perf_bad;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_acc  <= '0;
            r_perf_full <= '0;
            r_perf_bad  <= '0;
        end else begin
            if (w_commit   && r_perf_acc  != '1) r_perf_acc  <= r_perf_acc  + 32'd1;
            if (w_rej_full && r_perf_full != '1) r_perf_full <= r_perf_full + 32'd1;
            if (w_bad      && r_perf_bad  != '1) r_perf_bad  <= r_perf_bad  + 32'd1;
        end
    end

    assign perf_frames_accepted     = r_perf_acc;
    assign perf_frames_dropped_full = r_perf_full;
    assign perf_frames_dropped_bad  = r_perf_bad;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_rej_full ^ w_bad;
`endif

endmodule

// File: tb/tb_udp_rx_port_fifo.sv
// Directed bench for udp_rx_port_fifo with a 16-word payload FIFO so that
// the full and wrap-around cases are reachable with short datagrams.
module tb_udp_rx_port_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_start, rx_data_valid, rx_commit, rx_drop;
    logic [31:0] rx_src_ip, rx_data;
    logic [15:0] rx_src_port, rx_dst_port, rx_payload_len;
    logic [2:0]  rx_bytes_valid;
    logic        out_frame_valid, out_data_valid, out_rd_en, out_pop;
    logic [31:0] out_src_ip, out_data;
    logic [15:0] out_src_port, out_len;

    int n_tests = 0;
    int n_fail  = 0;

    udp_rx_port_fifo #(.LISTEN_PORT(16'd5000), .DATA_DEPTH(16), .FRAME_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .rx_start(rx_start), .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port),
        .rx_dst_port(rx_dst_port), .rx_payload_len(rx_payload_len),
        .rx_data_valid(rx_data_valid), .rx_bytes_valid(rx_bytes_valid),
        .rx_data(rx_data), .rx_commit(rx_commit), .rx_drop(rx_drop),
        .out_frame_valid(out_frame_valid), .out_src_ip(out_src_ip),
        .out_src_port(out_src_port), .out_len(out_len), .out_rd_en(out_rd_en),
        .out_data_valid(out_data_valid), .out_data(out_data), .out_pop(out_pop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // term: 0 commit, 1 drop, 2 none. with_last puts commit on the last word.
    task automatic send(input logic [15:0] dst, input logic [15:0] len, input int nw,
                        input logic [31:0] base, input int term, input bit with_last);
        rx_start       = 1'b1;
        rx_dst_port    = dst;
        rx_payload_len = len;
        rx_src_ip      = base ^ 32'hFFFF0000;
        rx_src_port    = base[15:0] ^ 16'h00FF;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            rx_data_valid  = 1'b1;
            rx_bytes_valid = 3'd4;
            rx_data        = base + 32'(i);
            if (with_last && i == nw - 1) rx_commit = 1'b1;
            tick();
        end
        rx_data_valid = 1'b0;
        if (!(with_last && nw > 0)) begin
            if (term == 0) rx_commit = 1'b1;
            if (term == 1) rx_drop   = 1'b1;
            if (term != 2) tick();
        end
        rx_commit = 1'b0;
        rx_drop   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] exp);
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;
        check({tag, " dv"}, 32'(out_data_valid), 32'd1);
        check({tag, " data"}, out_data, exp);
    endtask

    task automatic rd_none(input string tag);
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;
        check(tag, 32'(out_data_valid), 32'd0);
    endtask

    task automatic pop();
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rx_start = 0; rx_data_valid = 0; rx_commit = 0; rx_drop = 0;
        rx_src_ip = 0; rx_src_port = 0; rx_dst_port = 0; rx_payload_len = 0;
        rx_bytes_valid = 0; rx_data = 0; out_rd_en = 0; out_pop = 0;
        tick(); tick();
        check("rst fv",   32'(out_frame_valid), 32'd0);
        check("rst dv",   32'(out_data_valid),  32'd0);
        check("rst data", out_data,             32'd0);
        check("rst len",  32'(out_len),         32'd0);
        check("rst ip",   out_src_ip,           32'd0);
        check("rst port", 32'(out_src_port),    32'd0);
        rst = 1'b0;
        tick();

        // Single datagram, len 10 -> 3 words, visible 2 cycles after commit.
        send(16'd5000, 16'd10, 3, 32'h1000, 0, 1'b0);
        check("t1 fv early", 32'(out_frame_valid), 32'd0);
        tick();
        check("t1 fv",   32'(out_frame_valid), 32'd1);
        check("t1 len",  32'(out_len),         32'd10);
        check("t1 ip",   out_src_ip,           32'hFFFF1000);
        check("t1 port", 32'(out_src_port),    32'h10FF);
        rd("t1 w0", 32'h1000);
        rd("t1 w1", 32'h1001);
        rd("t1 w2", 32'h1002);
        rd_none("t1 w3 past end");
        pop();
        check("t1 fv after pop", 32'(out_frame_valid), 32'd0);

        // Wrong port: nothing buffered.
        send(16'd5001, 16'd8, 2, 32'h2000, 0, 1'b0);
        tick(); tick();
        check("t2 fv",     32'(out_frame_valid), 32'd0);
        check("t2 spec",   32'(dut.r_wr_spec),   32'd3);
        check("t2 commit", 32'(dut.r_wr_commit), 32'd3);

        // Dropped 8-word frame then good 2-word frame written from ptr 3.
        send(16'd5000, 16'd32, 8, 32'h3000, 1, 1'b0);
        send(16'd5000, 16'd8,  2, 32'h3100, 0, 1'b0);
        tick();
        check("t3 fv",     32'(out_frame_valid), 32'd1);
        check("t3 len",    32'(out_len),         32'd8);
        check("t3 commit", 32'(dut.r_wr_commit), 32'd5);
        rd("t3 w0", 32'h3100);
        rd("t3 w1", 32'h3101);
        rd_none("t3 past end");
        pop();

        // Zero-length datagram; a stray word beyond the length is ignored.
        send(16'd5000, 16'd0, 1, 32'h4000, 0, 1'b0);
        tick();
        check("t4 fv",  32'(out_frame_valid), 32'd1);
        check("t4 len", 32'(out_len),         32'd0);
        rd_none("t4 no data");
        check("t4 commit", 32'(dut.r_wr_commit), 32'd5);
        pop();
        check("t4 fv after pop", 32'(out_frame_valid), 32'd0);

        // Three frames ending at 8, 10, 15; partial read then pop.
        send(16'd5000, 16'd12, 3, 32'h5000, 0, 1'b0);
        send(16'd5000, 16'd8,  2, 32'h5100, 0, 1'b0);
        send(16'd5000, 16'd20, 5, 32'h5200, 0, 1'b0);
        tick();
        check("t5 len f1", 32'(out_len), 32'd12);
        rd("t5 f1 w0", 32'h5000);
        pop();
        check("t5 rd_ptr", 32'(dut.r_rd_ptr), 32'd8);
        check("t5 len f2", 32'(out_len),      32'd8);
        rd("t5 f2 w0", 32'h5100);
        pop();
        check("t5 len f3", 32'(out_len), 32'd20);
        pop();
        check("t5 fv empty", 32'(out_frame_valid), 32'd0);
        check("t5 rd_ptr end", 32'(dut.r_rd_ptr), 32'd15);

        // 12 words unread leave 4 free: a 6-word frame is rejected, then
        // accepted after the pop, wrapping from index 11 to index 0.
        send(16'd5000, 16'd48, 12, 32'h6000, 0, 1'b0);
        send(16'd5000, 16'd24, 6,  32'h6100, 0, 1'b0);
        tick();
        check("t6 fv",  32'(out_frame_valid), 32'd1);
        check("t6 len", 32'(out_len),         32'd48);
        pop();
        check("t6 rejected", 32'(out_frame_valid), 32'd0);
        send(16'd5000, 16'd24, 6, 32'h6100, 0, 1'b0);
        tick();
        check("t6 wrap fv",  32'(out_frame_valid), 32'd1);
        check("t6 wrap len", 32'(out_len),         32'd24);
        for (int i = 0; i < 6; i++) rd("t6 wrap word", 32'h6100 + 32'(i));
        rd_none("t6 wrap past end");
        pop();

        // Reset in the middle of an accepted frame with two frames queued.
        send(16'd5000, 16'd8, 2, 32'h7000, 0, 1'b0);
        send(16'd5000, 16'd8, 2, 32'h7100, 0, 1'b0);
        tick();
        check("t7 fv before rst", 32'(out_frame_valid), 32'd1);
        send(16'd5000, 16'd8, 1, 32'h7200, 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t7 rst fv",   32'(out_frame_valid), 32'd0);
        check("t7 rst data", out_data,             32'd0);
        check("t7 rst len",  32'(out_len),         32'd0);
        check("t7 rst ip",   out_src_ip,           32'd0);
        tick();
        rst = 1'b0;
        tick();

        // New frame after reset, commit on the same cycle as the last word.
        send(16'd5000, 16'd7, 2, 32'h8000, 0, 1'b1);
        check("t8 fv early", 32'(out_frame_valid), 32'd0);
        tick();
        check("t8 fv",     32'(out_frame_valid), 32'd1);
        check("t8 len",    32'(out_len),         32'd7);
        check("t8 ip",     out_src_ip,           32'hFFFF8000);
        check("t8 commit", 32'(dut.r_wr_commit), 32'd2);
        rd("t8 w0", 32'h8000);
        rd("t8 w1", 32'h8001);
        rd_none("t8 past end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
